// File: rtl/imem_boot_pkg.sv
// imem_boot_pkg: shared types for the instruction-memory boot loader.
// Frame length field width and FSM state encoding.
package imem_boot_pkg;

  localparam int BOOT_LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } boot_state_e;

endpackage

// File: rtl/imem_boot_if.sv
// imem_boot_if: byte-stream input, imem write port and status of the
// boot loader. master = image source / system, slave = controller.
interface imem_boot_if #(
  parameter int ADDR_W = 10
);

  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, rx_valid, rx_data,
    input  rx_ready, mem_we, mem_waddr,
    input  mem_wdata, core_hold,
    input  busy, done, err
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output rx_ready, mem_we, mem_waddr,
    output mem_wdata, core_hold,
    output busy, done, err
  );

endinterface

// File: rtl/imem_boot_word_asm.sv
// imem_boot_word_asm: packs accepted bytes little-endian into 32-bit
// words; word_valid flags the 4th byte with the completed word.
module imem_boot_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;

  // newest byte enters at the top so the first lands in [7:0]
  assign word       = {byte_data, sh_q[31:8]};
  assign word_valid = byte_valid && (cnt_q == 2'd3);

  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (clr) begin
      cnt_d = 2'd0;
    end else if (byte_valid) begin
      cnt_d = cnt_q + 2'd1;
      sh_d  = word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: loads a length-prefixed image into imem, holds core.
// Optional trailing checksum byte: define IMEM_BOOT_CSUM_EN.
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WORDS  = 256
) (
  input logic       clk,
  input logic       rst,
  imem_boot_if.slave bus
);

  localparam int IDX_W = ADDR_W - 2;

  boot_state_e             state_q, state_d;
  logic [7:0]              len_lo_q, len_lo_d;
  logic [BOOT_LEN_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       waddr_q, waddr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    ready_q, ready_d;
  logic                    hold_q, hold_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
`ifdef IMEM_BOOT_CSUM_EN
  logic [7:0]              sum_q, sum_d;
`endif

  logic                  acc;
  logic                  last;
  logic [BOOT_LEN_W-1:0] len_rx;
  logic                  word_valid;
  logic [31:0]           word;

  assign acc    = bus.rx_valid && ready_q;
  assign len_rx = {bus.rx_data, len_lo_q};
  assign last   = BOOT_LEN_W'(idx_q) ==
                  (len_q - BOOT_LEN_W'(1));

  imem_boot_word_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (state_q == LEN1),
    .byte_valid (acc && (state_q == DATA)),
    .byte_data  (bus.rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    idx_d    = idx_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
`ifdef IMEM_BOOT_CSUM_EN
    sum_d    = sum_q;
`endif
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.start) state_d = LEN0;
      end
      LEN0: begin
        if (acc) begin
          len_lo_d = bus.rx_data;
          state_d  = LEN1;
        end
      end
      LEN1: begin
        if (acc) begin
          if (len_rx == '0 ||
              len_rx > BOOT_LEN_W'(WORDS)) begin
            state_d = ERR;
          end else begin
            len_d   = len_rx;
            idx_d   = '0;
            state_d = DATA;
`ifdef IMEM_BOOT_CSUM_EN
            sum_d   = 8'd0;
`endif
          end
        end
      end
      DATA: begin
`ifdef IMEM_BOOT_CSUM_EN
        if (acc) sum_d = sum_q + bus.rx_data;
`endif
        if (word_valid) begin
          we_d    = 1'b1;
          waddr_d = {idx_q, 2'b00};
          wdata_d = word;
          idx_d   = idx_q + IDX_W'(1);
`ifdef IMEM_BOOT_CSUM_EN
          if (last) state_d = CSUM;
`else
          if (last) state_d = DONE;
`endif
        end
      end
`ifdef IMEM_BOOT_CSUM_EN
      CSUM: begin
        if (acc) begin
          state_d = (bus.rx_data == sum_q) ? DONE : ERR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // status outputs are registered copies of the next state
  always_comb begin
    ready_d = (state_d == LEN0) || (state_d == LEN1) ||
              (state_d == DATA) || (state_d == CSUM);
    hold_d  = (state_d != DONE);
    done_d  = (state_d == DONE);
    err_d   = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      len_lo_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef IMEM_BOOT_CSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef IMEM_BOOT_CSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign bus.rx_ready  = ready_q;
  assign bus.busy      = ready_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_waddr = waddr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.core_hold = hold_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl: directed + random frames against a word-list model
// of the boot loader; imem writes captured by a negedge monitor.
module tb_imem_boot_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_boot_if #(.ADDR_W(10)) bus ();

  imem_boot_ctrl #(
    .ADDR_W (10),
    .WORDS  (256)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int drops    = 0;
  int stalls   = 0;
  bit mid      = 1'b0;

  logic [31:0] words[$];
  logic [7:0]  frame[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wa_q.push_back(32'(bus.mem_waddr));
      wd_q.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sum_of();
    logic [7:0] s = 8'd0;
    foreach (words[i])
      for (int k = 0; k < 4; k++)
        s = s + words[i][8*k +: 8];
    return s;
  endfunction

  function automatic bit len_ok(input int len);
    return len >= 1 && len <= 256;
  endfunction

  task automatic build_frame(input logic [15:0] len);
    frame.delete();
    frame.push_back(len[7:0]);
    frame.push_back(len[15:8]);
    foreach (words[i])
      for (int k = 0; k < 4; k++)
        frame.push_back(words[i][8*k +: 8]);
  endtask

  task automatic add_sum();
`ifdef IMEM_BOOT_CSUM_EN
    frame.push_back(sum_of());
`endif
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++)
      words.push_back($urandom());
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int gap);
    int n;
    bus.rx_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      if (mid && bus.rx_ready !== 1'b1) drops++;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (mid) stalls += n;
    if (n >= 40) check("rx_ready_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi,
                            input int maxgap);
    mid = 1'b1;
    for (int i = lo; i < hi; i++)
      send_byte(frame[i], int'($urandom_range(0, maxgap)));
    mid = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_writes(input string tag,
                              input int nexp);
    check({tag, "_nwr"}, 32'(wa_q.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < wa_q.size(); i++) begin
      check({tag, "_addr"}, wa_q[i], 32'(i * 4));
      check({tag, "_data"}, wd_q[i], words[i]);
    end
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic check_status(input string tag,
                              input bit ok);
    check({tag, "_done"}, 32'(bus.done), 32'(ok));
    check({tag, "_err"},  32'(bus.err),  32'(!ok));
    check({tag, "_hold"}, 32'(bus.core_hold), 32'(!ok));
    check({tag, "_rdy"},  32'(bus.rx_ready), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_rdy",   32'(bus.rx_ready),  32'd0);
    check("rst_we",    32'(bus.mem_we),    32'd0);
    check("rst_addr",  32'(bus.mem_waddr), 32'd0);
    check("rst_data",  bus.mem_wdata,      32'd0);
    check("rst_hold",  32'(bus.core_hold), 32'd1);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_done",  32'(bus.done),      32'd0);
    check("rst_err",   32'(bus.err),       32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic two-word image
    words = '{32'h0000_0013, 32'h0010_0093};
    build_frame(16'd2);
    add_sum();
    do_start();
    send_range(0, frame.size(), 0);
    repeat (2) @(negedge clk);
    check_writes("s1", 2);
    check_status("s1", 1'b1);

    // illegal lengths
    words.delete();
    build_frame(16'd0);
    do_start();
    send_range(0, frame.size(), 0);
    repeat (2) @(negedge clk);
    check_writes("s2a", 0);
    check_status("s2a", len_ok(0));
    build_frame(16'd257);
    do_start();
    send_range(0, frame.size(), 0);
    repeat (2) @(negedge clk);
    check_writes("s2b", 0);
    check_status("s2b", len_ok(257));

    // valid gaps: directed image then random images
    words = '{32'h0000_0013, 32'h0010_0093};
    build_frame(16'd2);
    add_sum();
    drops  = 0;
    stalls = 0;
    do_start();
    send_range(0, frame.size(), 5);
    repeat (2) @(negedge clk);
    check_writes("s3", 2);
    check_status("s3", 1'b1);
    for (int r = 0; r < 3; r++) begin
      rand_words(int'($urandom_range(1, 8)));
      build_frame(16'(words.size()));
      add_sum();
      do_start();
      send_range(0, frame.size(), 5);
      repeat (2) @(negedge clk);
      check_writes("s3r", words.size());
      check_status("s3r", 1'b1);
    end
    check("s3_drops",  32'(drops),  32'd0);
    check("s3_stalls", 32'(stalls), 32'd0);

    // reset after 6 data bytes
    rand_words(2);
    build_frame(16'd2);
    do_start();
    send_range(0, 8, 0);
    rst = 1'b1;
    #1;
    check("s4_busy", 32'(bus.busy),      32'd0);
    check("s4_rdy",  32'(bus.rx_ready),  32'd0);
    check("s4_hold", 32'(bus.core_hold), 32'd1);
    check("s4_we",   32'(bus.mem_we),    32'd0);
    check_writes("s4", 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // start and first byte together in IDLE: byte waits for LEN0
    rand_words(1);
    build_frame(16'd1);
    add_sum();
    bus.rx_valid = 1'b1;
    bus.rx_data  = frame[0];
    do_start();
    send_range(0, frame.size(), 0);
    repeat (2) @(negedge clk);
    check_writes("s4i", 1);
    check_status("s4i", 1'b1);

    // start during DATA ignored
    rand_words(1);
    build_frame(16'd1);
    add_sum();
    do_start();
    send_range(0, 4, 0);
    do_start();
    send_range(4, frame.size(), 0);
    repeat (2) @(negedge clk);
    check_writes("s5", 1);
    check_status("s5", 1'b1);

    // reload from DONE re-holds the core
    rand_words(1);
    build_frame(16'd1);
    add_sum();
    do_start();
    check("s5r_hold0", 32'(bus.core_hold), 32'd1);
    check("s5r_done0", 32'(bus.done),      32'd0);
    send_range(0, frame.size() - 1, 0);
    check("s5r_hold1", 32'(bus.core_hold), 32'd1);
    send_range(frame.size() - 1, frame.size(), 0);
    repeat (2) @(negedge clk);
    check_writes("s5r", 1);
    check_status("s5r", 1'b1);

`ifdef IMEM_BOOT_CSUM_EN
    words = '{32'h0000_0013, 32'h0010_0093};
    build_frame(16'd2);
    frame.push_back(8'hB6);
    do_start();
    send_range(0, frame.size(), 0);
    repeat (2) @(negedge clk);
    check_writes("s6a", 2);
    check_status("s6a", sum_of() == 8'hB6);
    build_frame(16'd2);
    frame.push_back(8'hB7);
    do_start();
    send_range(0, frame.size(), 0);
    repeat (2) @(negedge clk);
    check_writes("s6b", 2);
    check_status("s6b", sum_of() == 8'hB7);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
